// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Package pipeline_ctrl_pkg: shared definitions for the pipeline hazard
// controller and its helpers.
//   state_t              : controller FSM state encoding
//   REG_X0               : architectural zero register index
//   MDU_TIMEOUT_DEFAULT  : default watchdog limit for a multi-cycle MDU op
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int MDU_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface pipeline_hazard_ctrl_if: groups the hazard controller's pipeline
// facing signals.
//   master modport : pipeline datapath side (drives hazard inputs, receives
//                    stall/flush controls)
//   slave modport  : hazard controller side
// Inputs to the controller: id_rs1, id_rs2, id_use_rs1, id_use_rs2,
//   ex_mem_read, ex_rd, ex_redirect, ex_mdu_op, mdu_done.
// Outputs from the controller: pc_stall, if_id_stall, if_id_flush,
//   id_ex_stall, id_ex_flush, ex_mem_flush, mdu_start, mdu_timeout.
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       ex_mdu_op;
  logic       mdu_done;

  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mdu_start;
  logic mdu_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_mem_read, ex_rd, ex_redirect, ex_mdu_op, mdu_done,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_flush, mdu_start, mdu_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_mem_read, ex_rd, ex_redirect, ex_mdu_op, mdu_done,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_flush, mdu_start, mdu_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_loaduse_cmp.sv
// Module hazard_loaduse_cmp: pure combinational load-use hazard detector.
// Flags when the load in EX writes a register that the instruction in ID
// reads. Writes to x0 never create a hazard.
//   rs1, rs2         in  source register fields of the ID instruction
//   use_rs1, use_rs2 in  ID instruction actually reads rs1 / rs2
//   mem_read         in  EX instruction is a load
//   rd               in  destination register of the EX instruction
//   lu               out load-use hazard present
module hazard_loaduse_cmp
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       mem_read,
  input  logic [4:0] rd,
  output logic       lu
);

  assign lu = mem_read && (rd != REG_X0) &&
              ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Module pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage
// RV32IM pipeline. Handles load-use bubbles, wrong-path squash on an EX
// redirect, and front-end freeze while a multi-cycle MDU op runs in EX,
// guarded by a sticky watchdog.
// Ports:
//   CLK    in  system clock, rising edge
//   Reset  in  synchronous active-high reset; forces every output to 0
//   hz     slave modport of pipeline_hazard_ctrl_if (hazard inputs and
//          stall/flush/mdu controls)
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters:
//   perf_lu_stalls   out  cycles spent inserting a load-use bubble
//   perf_mdu_stalls  out  MDU_WAIT cycles without mdu_done
//   perf_flushes     out  redirect cycles
// Parameters: MDU_TIMEOUT (watchdog limit in MDU_WAIT cycles) and CNT_W
// (watchdog width, 2**CNT_W must exceed MDU_TIMEOUT).
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 7
) (
  input  logic CLK,
  input  logic Reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mdu_stalls,
  output logic [31:0] perf_flushes
`endif
);

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MDU_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wdog;
  logic             timeout_q;

  logic lu;
  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mdu_start;
  logic wdog_clear;
  logic wdog_inc;
  logic timeout_set;
  logic lu_cycle;
  logic mdu_stall_cycle;
  logic redirect_cycle;

  hazard_loaduse_cmp u_lu_cmp (
    .rs1      (hz.id_rs1),
    .rs2      (hz.id_rs2),
    .use_rs1  (hz.id_use_rs1),
    .use_rs2  (hz.id_use_rs2),
    .mem_read (hz.ex_mem_read),
    .rd       (hz.ex_rd),
    .lu       (lu)
  );

  // Control decode. Everything is gated by Reset so no pulse escapes while
  // the pipeline is being reset. In MDU_WAIT, ex_mdu_op is deliberately not
  // looked at: on the done cycle EX still holds the op and must not restart
  // the MDU.
  always_comb begin
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_stall     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    mdu_start       = 1'b0;
    wdog_clear      = 1'b0;
    wdog_inc        = 1'b0;
    timeout_set     = 1'b0;
    lu_cycle        = 1'b0;
    mdu_stall_cycle = 1'b0;
    redirect_cycle  = 1'b0;
    next_state      = state;
    if (!Reset) begin
      unique case (state)
        RUN: begin
          if (hz.ex_redirect) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_cycle = 1'b1;
          end else if (hz.ex_mdu_op) begin
            mdu_start    = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            wdog_clear   = 1'b1;
            next_state   = MDU_WAIT;
          end else if (lu) begin
            // One bubble is enough: next cycle EX holds the bubble.
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            lu_cycle    = 1'b1;
          end
        end
        MDU_WAIT: begin
          if (hz.mdu_done) begin
            next_state = RUN;
          end else begin
            pc_stall        = 1'b1;
            if_id_stall     = 1'b1;
            id_ex_stall     = 1'b1;
            ex_mem_flush    = 1'b1;
            mdu_stall_cycle = 1'b1;
            if (wdog == WDOG_LAST) begin
              // Give up on the MDU; stalls drop from the next cycle.
              timeout_set = 1'b1;
              next_state  = RUN;
            end else begin
              wdog_inc = 1'b1;
            end
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // FSM state, watchdog and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= RUN;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= next_state;
      if (wdog_clear) begin
        wdog <= '0;
      end else if (wdog_inc) begin
        wdog <= wdog + 1'b1;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign hz.pc_stall     = pc_stall;
  assign hz.if_id_stall  = if_id_stall;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_stall  = id_ex_stall;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.mdu_start    = mdu_start;
  assign hz.mdu_timeout  = timeout_q && !Reset;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      perf_lu_stalls  <= '0;
      perf_mdu_stalls <= '0;
      perf_flushes    <= '0;
    end else begin
      if (lu_cycle && (perf_lu_stalls != 32'hFFFF_FFFF)) begin
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      end
      if (mdu_stall_cycle && (perf_mdu_stalls != 32'hFFFF_FFFF)) begin
        perf_mdu_stalls <= perf_mdu_stalls + 32'd1;
      end
      if (redirect_cycle && (perf_flushes != 32'hFFFF_FFFF)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`else
  logic unused_perf;
  assign unused_perf = lu_cycle ^ mdu_stall_cycle ^ redirect_cycle;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed cycle-by-cycle vectors with
// hand-computed expected control words.
// Control word bit order:
//   {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
//    id_ex_flush, ex_mem_flush, mdu_start, mdu_timeout}
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] W_IDLE  = 8'b0000_0000;
  localparam logic [7:0] W_LU    = 8'b1100_1000;
  localparam logic [7:0] W_REDIR = 8'b0010_1000;
  localparam logic [7:0] W_START = 8'b1101_0110;
  localparam logic [7:0] W_WAIT  = 8'b1101_0100;
  localparam logic [7:0] W_TOUT  = 8'b0000_0001;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipeline_hazard_ctrl_if hzIf ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfLuStalls;
  logic [31:0] perfMduStalls;
  logic [31:0] perfFlushes;
`endif

  pipeline_hazard_ctrl dut (
    .CLK   (clk),
    .Reset (reset),
    .hz    (hzIf.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lu_stalls  (perfLuStalls),
    .perf_mdu_stalls (perfMduStalls),
    .perf_flushes    (perfFlushes)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] observed;
  assign observed = {hzIf.pc_stall, hzIf.if_id_stall, hzIf.if_id_flush,
                     hzIf.id_ex_stall, hzIf.id_ex_flush, hzIf.ex_mem_flush,
                     hzIf.mdu_start, hzIf.mdu_timeout};

  // Drive every controller input for the coming cycle.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic useRs1, input logic useRs2,
                               input logic memRead, input logic [4:0] rd,
                               input logic redirect, input logic mduOp,
                               input logic done);
    hzIf.id_rs1      = rs1;
    hzIf.id_rs2      = rs2;
    hzIf.id_use_rs1  = useRs1;
    hzIf.id_use_rs2  = useRs2;
    hzIf.ex_mem_read = memRead;
    hzIf.ex_rd       = rd;
    hzIf.ex_redirect = redirect;
    hzIf.ex_mdu_op   = mduOp;
    hzIf.mdu_done    = done;
  endtask

  // Compare the control word mid-cycle, then advance past the next edge.
  task automatic checkOutput(input string tag, input logic [7:0] expected);
    @(negedge clk);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] expected);
    checks++;
    assert (obs === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with redirect and MDU op asserted: everything stays quiet.
    reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_quiet_0", W_IDLE);
    checkOutput("reset_quiet_1", W_IDLE);
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_idle", W_IDLE);

    // Load-use on rs2, then EX holds the bubble.
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2", W_LU);
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_bubble_clear", W_IDLE);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rd_x0", W_IDLE);
    applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1", W_LU);
    applyStimulus(5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1_unused", W_IDLE);
    applyStimulus(5'd7, 5'd9, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_no_match", W_IDLE);
    applyStimulus(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_not_load", W_IDLE);

    // Redirect wins over load-use and over an MDU op.
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("redirect_over_lu", W_REDIR);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("redirect_over_mdu", W_REDIR);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("redirect_stays_run", W_IDLE);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("done_in_run_ignored", W_IDLE);

    // MDU op (with a coincident load-use) completing after 33 wait cycles.
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
    checkOutput("mdu33_start", W_START);
    for (int i = 0; i < 33; i++) begin
      if (i == 10) begin
        applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      end else begin
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      end
      checkOutput($sformatf("mdu33_wait_%0d", i), W_WAIT);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mdu33_done", W_IDLE);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mdu33_after", W_IDLE);

    // MDU op that never finishes: 64 stalled wait cycles, then sticky error.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("tout_start", W_START);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("tout_wait_%0d", i), W_WAIT);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("tout_flag", W_TOUT);
    checkOutput("tout_sticky", W_TOUT);
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("tout_back_in_run", W_LU | W_TOUT);

    // Reset in the middle of an MDU op returns quietly to RUN.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("rstmid_start", W_START | W_TOUT);
    checkOutput("rstmid_wait", W_WAIT | W_TOUT);
    reset = 1'b1;
    checkOutput("rstmid_during_reset", W_IDLE);
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstmid_released_run", W_IDLE);

    // Back-to-back MDU ops, 5 wait cycles each; second starts right after.
    reset = 1'b1;
    checkOutput("b2b_reset", W_IDLE);
    reset = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int op = 0; op < 2; op++) begin
      checkOutput($sformatf("b2b_start_%0d", op), W_START);
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("b2b_wait_%0d_%0d", op, i), W_WAIT);
      end
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("b2b_done_%0d", op), W_IDLE);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, (op == 0), 1'b0);
    end
    checkOutput("b2b_after", W_IDLE);

`ifdef HAZARD_PERF_CNT_EN
    checkValue("perf_mdu_stalls", perfMduStalls, 32'd10);
    checkValue("perf_lu_stalls", perfLuStalls, 32'd0);
    checkValue("perf_flushes", perfFlushes, 32'd0);
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("perf_redirect", W_REDIR);
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("perf_lu", W_LU);
    checkValue("perf_flushes_1", perfFlushes, 32'd1);
    checkValue("perf_lu_stalls_1", perfLuStalls, 32'd1);
`else
    checkValue("no_perf_timeout_clear", {31'd0, hzIf.mdu_timeout}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the RV32IM 5-stage pipeline.
- Drives the hold/bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, squashes wrong-path instructions on a taken branch or jump resolved in EX, and freezes the front end while a multi-cycle M-extension op (DIV/REM, iterative MUL) runs in EX.
- Sits beside the ID/EX register and is the only source of its stall/flush inputs.

Parameters:
- MDU_TIMEOUT, 64: maximum cycles allowed in MDU_WAIT before the watchdog fires.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > MDU_TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- ex_mdu_op  in  1  EX holds a multi-cycle MDU op.
- mdu_done  in  1  MDU result valid; single-cycle pulse.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_stall  out  1  hold the ID/EX register.
- id_ex_flush  out  1  load a bubble into ID/EX (all control bits 0).
- ex_mem_flush  out  1  load a bubble into EX/MEM.
- mdu_start  out  1  one-cycle start pulse to the MDU.
- mdu_timeout  out  1  sticky watchdog error flag.

Behaviour:
- All outputs are 0 on any cycle with Reset=1.
- Registered state after Reset: state=RUN, wdog=0, mdu_timeout=0.
- Reset mid-MDU returns to RUN on the next edge with no start or flush pulses emitted.
- Outputs are combinational from state plus inputs. State, wdog and mdu_timeout update on the CLK rising edge only.
- FSM states:
  - RUN: normal flow.
  - MDU_WAIT: front end frozen pending mdu_done.
- Load-use condition lu:
  - ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN, priority highest first:
  1. ex_redirect=1: if_id_flush=1, id_ex_flush=1, no stalls, lu ignored. Stay in RUN.
  2. ex_mdu_op=1: mdu_start=1, pc_stall=if_id_stall=id_ex_stall=1, ex_mem_flush=1. Next state MDU_WAIT, wdog<=0.
  3. lu=1: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble); ex_mem_flush=0. Stay in RUN. Re-evaluated each cycle; a second cycle is never needed because EX then holds the bubble.
  4. Otherwise all outputs 0.
- MDU_WAIT:
  - mdu_done=0: pc_stall=if_id_stall=id_ex_stall=1, ex_mem_flush=1, wdog<=wdog+1.
  - mdu_done=1: all stalls 0, ex_mem_flush=0 so the result advances; next state RUN. This cycle ex_mdu_op is still 1 and must NOT restart the MDU.
  - wdog==MDU_TIMEOUT-1 and mdu_done=0: mdu_timeout<=1, next state RUN; stalls drop on the following cycle.
  - ex_redirect and lu are ignored in MDU_WAIT.
  - mdu_done in RUN is ignored.
- Back-to-back MDU ops:
  - The next MDU op enters EX one cycle after release and starts normally from RUN.
  - One-cycle gap between mdu_done and the next mdu_start.
- mdu_timeout clears only on Reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit output ports:
  - perf_lu_stalls: cycles with lu bubble.
  - perf_mdu_stalls: cycles in MDU_WAIT with mdu_done=0.
  - perf_flushes: redirect cycles.
- All three reset to 0 on Reset, saturate at 32'hFFFFFFFF and never wrap.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state enum (RUN=1'b0, MDU_WAIT=1'b1);
  - REG_X0=5'd0;
  - default MDU_TIMEOUT.
- One natural sub-module: hazard_loaduse_cmp, the pure combinational lu comparator, reusable by the forwarding unit.

Test Plan:
- Reset=1 with ex_redirect=1 and ex_mdu_op=1 -> every output 0; after release, state RUN, mdu_timeout=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1. Same stimulus with ex_rd=0 -> no stall.
- Redirect coincident with lu (ex_redirect=1, lu=1) -> if_id_flush=id_ex_flush=1, pc_stall=0.
- MDU op, mdu_done after 33 cycles -> mdu_start high 1 cycle; stalls and ex_mem_flush high 33 cycles; all 0 on the done cycle; no second mdu_start.
- MDU op, mdu_done never arrives, MDU_TIMEOUT=64 -> stalls high 64 cycles, mdu_timeout=1 and sticky, state back to RUN.
- Two MDU ops back-to-back, each done after 5 cycles -> start pulses spaced 7 cycles apart. With HAZARD_PERF_CNT_EN defined, perf_mdu_stalls=10.
